pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding/flush controller for the in-order RISC-V pipeline.
//  Tracks in-flight destination registers in a shadow pipeline of DEPTH post-ID slots.
//  Produces PC/IF-ID stall, IF-ID flush, ID-EX bubble, EX hold and per-source EX forwarding selects.
//  Supports variable load latency, multi-cycle EX units (ex_busy) and saturating stall/flush counters.
// PARAMETERS
//  RF_ADDRESS 5   register address width
//  NUM_SRC    2   source operands per instruction (2 or 3)
//  DEPTH      3   shadow slots after ID (slot1=EX ... slotDEPTH=WB); 3..8
//  LOAD_LAT   1   extra stages before load data is forwardable; 2+LOAD_LAT <= DEPTH
//  CNT_W      32  perf counter width
//  FS_W = $clog2(DEPTH) (localparam) forwarding select width
// PORTS
//  clk          in  1                  clock
//  reset        in  1                  asynchronous, active-high
//  id_valid     in  1                  valid instruction in ID
//  id_rs        in  NUM_SRC*RF_ADDRESS source regs, src s at [s*RF_ADDRESS +: RF_ADDRESS]
//  id_rs_used   in  NUM_SRC            source s actually read
//  id_rd        in  RF_ADDRESS         destination reg
//  id_regwrite  in  1                  ID instruction writes rd
//  id_memread   in  1                  ID instruction is a load
//  ex_busy      in  1                  multi-cycle EX unit not done
//  ex_redirect  in  1                  taken branch/jump resolved in EX
//  pc_stall     out 1                  hold PC
//  if_id_stall  out 1                  hold IF/ID register
//  if_id_flush  out 1                  clear IF/ID register
//  id_ex_bubble out 1                  load NOP into ID/EX
//  ex_hold      out 1                  hold ID/EX, NOP into EX/MEM
//  fwd_sel      out NUM_SRC*FS_W       per source: 0=ID/EX operand, k=slot k+1 result
//  stall_cnt    out CNT_W              cycles with pc_stall=1, saturating
//  flush_cnt    out CNT_W              accepted redirects, saturating
// BEHAVIOUR
//  Reset: all slots invalid, ex_first=0, counters 0, all outputs 0. Mid-operation reset clears immediately.
//  Slot k: {valid, rd, wen, load, rs[], first}. Avail slot AV = 2 (non-load) or 2+LOAD_LAT (load).
//  Match: producer valid & wen & rd!=0 & rd==rs & rs_used; youngest (lowest slot) match only.
//  Load-use (comb, ID): match in slot j<DEPTH with j+1 < AV -> luh=1. Slot DEPTH match needs no action
//    (RegFile is write-first).
//  Priority per cycle: ex_busy > ex_redirect > luh.
//   ex_busy: pc_stall=if_id_stall=ex_hold=1, flush/bubble=0; slot1 holds; slot2<=bubble;
//     slot k+1<=slot k for k>=2.
//   ex_redirect (!ex_busy): if_id_flush=id_ex_bubble=1, stalls 0; slot1<=bubble; flush_cnt+1.
//   luh (neither above): pc_stall=if_id_stall=id_ex_bubble=1; slot1<=bubble.
//   else: slot1<=ID instr if id_valid, else bubble.
//   In all non-busy cases slot k+1<=slot k.
//  fwd_sel (comb): for slot1 valid & first & source used, youngest match in slots 2..DEPTH -> k-1;
//    else 0. Slot1 match is impossible (self).
//  first=1 on slot1 entry, cleared after first cycle; operands latched by EX on first cycle, so
//    fwd_sel=0 during later ex_busy hold cycles.
//  Counters saturate at all-ones; no wrap.
// TESTING
//  add x5,x1,x2; add x6,x5,x5 -> no stall; in EX of 2nd: fwd_sel src0=src1=1.
//  lw x5; add x6,x5,x0 (LOAD_LAT=1,DEPTH=3) -> 1 cycle pc_stall+id_ex_bubble; then fwd_sel src0=2; stall_cnt=1.
//  DEPTH=4,LOAD_LAT=2: lw x7; or x8,x7,x7 -> 2 stall cycles, then fwd_sel=3; stall_cnt=2.
//  luh with ex_redirect same cycle -> pc_stall=0, if_id_flush=id_ex_bubble=1, flush_cnt=1.
//  ex_busy high 3 cycles -> ex_hold/pc_stall 3 cycles, EX/MEM bubbles; fwd_sel 0 after cycle 1; stall_cnt=3.
//  Producer rd=x0 followed by rs=x0 user -> no stall, fwd_sel=0; reset mid-stall -> outputs 0 next sample.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush control for an in-order pipeline.
// In-flight writers are tracked in a shadow pipeline of DEPTH post-ID slots (slot1=EX).
module pipe_hazard_ctrl #(
  parameter int RF_ADDRESS = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32,
  localparam int FS_W      = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [NUM_SRC*RF_ADDRESS-1:0] id_rs,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [RF_ADDRESS-1:0]         id_rd,
  input  logic                          id_regwrite,
  input  logic                          id_memread,
  input  logic                          ex_busy,
  input  logic                          ex_redirect,
  output logic                          pc_stall,
  output logic                          if_id_stall,
  output logic                          if_id_flush,
  output logic                          id_ex_bubble,
  output logic                          ex_hold,
  output logic [NUM_SRC*FS_W-1:0]       fwd_sel,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              flush_cnt
);

  typedef struct packed {
    logic                  vld;
    logic                  wen;
    logic                  load;
    logic [RF_ADDRESS-1:0] rd;
  } slot_t;

  slot_t                         r_slot [1:DEPTH];
  logic [NUM_SRC*RF_ADDRESS-1:0] r_ex_rs;
  logic [NUM_SRC-1:0]            r_ex_rs_used;
  logic                          r_ex_first;
  logic [CNT_W-1:0]              r_stall_cnt;
  logic [CNT_W-1:0]              r_flush_cnt;

  logic                    w_luh;
  logic                    w_luh_hit;
  logic                    w_fwd_hit;
  logic                    w_luh_act;
  logic                    w_redir_act;
  logic                    w_stall_int;
  logic                    w_take_id;
  logic [NUM_SRC*FS_W-1:0] w_fwd_sel;

  function automatic logic f_match(input slot_t s, input logic [RF_ADDRESS-1:0] rs);
    return s.vld && s.wen && (s.rd != '0) && (s.rd == rs);
  endfunction

  // Only the youngest writer of a register matters; an older load behind it is shadowed.
  always_comb begin
    w_luh     = 1'b0;
    w_luh_hit = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      w_luh_hit = 1'b0;
      if (id_valid && id_rs_used[s]) begin
        for (int j = 1; j <= DEPTH; j++) begin
          if (!w_luh_hit && f_match(r_slot[j], id_rs[s*RF_ADDRESS +: RF_ADDRESS])) begin
            w_luh_hit = 1'b1;
            if (r_slot[j].load && (j < DEPTH) && (j + 1 < 2 + LOAD_LAT))
              w_luh = 1'b1;
          end
        end
      end
    end
  end

  // Operands are captured on the first EX cycle only, so later hold cycles select the ID/EX value.
  always_comb begin
    w_fwd_sel = '0;
    w_fwd_hit = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      w_fwd_hit = 1'b0;
      if (r_slot[1].vld && r_ex_first && r_ex_rs_used[s]) begin
        for (int k = 2; k <= DEPTH; k++) begin
          if (!w_fwd_hit && f_match(r_slot[k], r_ex_rs[s*RF_ADDRESS +: RF_ADDRESS])) begin
            w_fwd_hit = 1'b1;
            w_fwd_sel[s*FS_W +: FS_W] = FS_W'(k - 1);
          end
        end
      end
    end
  end

  assign w_redir_act = ex_redirect && !ex_busy;
  assign w_luh_act   = w_luh && !ex_busy && !ex_redirect;
  assign w_stall_int = ex_busy || w_luh_act;
  assign w_take_id   = id_valid && !w_redir_act && !w_luh_act;

  assign pc_stall     = !reset && w_stall_int;
  assign if_id_stall  = !reset && w_stall_int;
  assign if_id_flush  = !reset && w_redir_act;
  assign id_ex_bubble = !reset && (w_redir_act || w_luh_act);
  assign ex_hold      = !reset && ex_busy;
  assign fwd_sel      = reset ? '0 : w_fwd_sel;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) r_slot[k] <= '0;
      r_ex_rs      <= '0;
      r_ex_rs_used <= '0;
      r_ex_first   <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (ex_busy) begin
        // EX holds its instruction; a bubble leaves toward MEM while older slots drain.
        r_ex_first <= 1'b0;
        r_slot[2]  <= '0;
        for (int k = 3; k <= DEPTH; k++) r_slot[k] <= r_slot[k-1];
      end else begin
        for (int k = 2; k <= DEPTH; k++) r_slot[k] <= r_slot[k-1];
        if (w_take_id) begin
          r_slot[1].vld  <= 1'b1;
          r_slot[1].wen  <= id_regwrite;
          r_slot[1].load <= id_memread;
          r_slot[1].rd   <= id_rd;
          r_ex_rs        <= id_rs;
          r_ex_rs_used   <= id_rs_used;
          r_ex_first     <= 1'b1;
        end else begin
          r_slot[1]    <= '0;
          r_ex_rs_used <= '0;
          r_ex_first   <= 1'b0;
        end
      end

      if (w_stall_int && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_redir_act && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default config (a_*) and DEPTH=4/LOAD_LAT=2/CNT_W=2 config (b_*).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [9:0] id_rs;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       ex_busy;
  logic       ex_redirect;

  logic        a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_bubble, a_ex_hold;
  logic [3:0]  a_fwd_sel;
  logic [31:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_bubble, b_ex_hold;
  logic [3:0]  b_fwd_sel;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_busy(ex_busy), .ex_redirect(ex_redirect),
    .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall), .if_id_flush(a_if_id_flush),
    .id_ex_bubble(a_id_ex_bubble), .ex_hold(a_ex_hold), .fwd_sel(a_fwd_sel),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipe_hazard_ctrl #(.DEPTH(4), .LOAD_LAT(2), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_busy(ex_busy), .ex_redirect(ex_redirect),
    .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall), .if_id_flush(b_if_id_flush),
    .id_ex_bubble(b_id_ex_bubble), .ex_hold(b_ex_hold), .fwd_sel(b_fwd_sel),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                        input logic [4:0] rd, input logic mem);
    id_valid    = 1'b1;
    id_rs       = {rs1, rs0};
    id_rs_used  = used;
    id_rd       = rd;
    id_regwrite = 1'b1;
    id_memread  = mem;
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_rs       = '0;
    id_rs_used  = '0;
    id_rd       = '0;
    id_regwrite = 1'b0;
    id_memread  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    ex_busy     = 1'b0;
    ex_redirect = 1'b0;
    reset       = 1'b1;
    tick();
    reset       = 1'b0;
  endtask

  initial begin
    // Reset with ex_busy driven: every output must stay low.
    idle();
    reset       = 1'b1;
    ex_busy     = 1'b1;
    ex_redirect = 1'b1;
    #3;
    chk("rst_pc_stall", a_pc_stall, 0);
    chk("rst_ex_hold", a_ex_hold, 0);
    chk("rst_flush", a_if_id_flush, 0);
    chk("rst_fwd", a_fwd_sel, 0);
    chk("rst_stall_cnt", a_stall_cnt, 0);
    tick();
    reset = 1'b0; ex_busy = 1'b0; ex_redirect = 1'b0;

    // add x5,x1,x2 ; add x6,x5,x5
    set_id(5'd1, 5'd2, 2'b11, 5'd5, 1'b0); #2;
    chk("alu_pc_stall0", a_pc_stall, 0);
    tick();
    set_id(5'd5, 5'd5, 2'b11, 5'd6, 1'b0); #2;
    chk("alu_pc_stall1", a_pc_stall, 0);
    tick();
    idle(); #2;
    chk("alu_fwd", a_fwd_sel, 4'b0101);

    // lw x5 ; add x6,x5,x0 (LOAD_LAT=1)
    tick();
    set_id(5'd1, 5'd0, 2'b01, 5'd5, 1'b1);
    tick();
    set_id(5'd5, 5'd0, 2'b11, 5'd6, 1'b0); #2;
    chk("lu_pc_stall", a_pc_stall, 1);
    chk("lu_bubble", a_id_ex_bubble, 1);
    chk("lu_if_id_stall", a_if_id_stall, 1);
    tick(); #1;
    chk("lu_release", a_pc_stall, 0);
    tick();
    idle(); #2;
    chk("lu_fwd", a_fwd_sel, 4'b0010);
    chk("lu_stall_cnt", a_stall_cnt, 1);

    // DEPTH=4, LOAD_LAT=2: lw x7 ; or x8,x7,x7
    do_reset();
    set_id(5'd1, 5'd0, 2'b01, 5'd7, 1'b1);
    tick();
    set_id(5'd7, 5'd7, 2'b11, 5'd8, 1'b0); #2;
    chk("b_stall1", b_pc_stall, 1);
    tick(); #1;
    chk("b_stall2", b_pc_stall, 1);
    chk("b_bubble2", b_id_ex_bubble, 1);
    tick(); #1;
    chk("b_release", b_pc_stall, 0);
    tick();
    idle(); #2;
    chk("b_fwd", b_fwd_sel, 4'b1111);
    chk("b_stall_cnt", b_stall_cnt, 2);
    ex_busy = 1'b1; #1;
    chk("b_ex_hold", b_ex_hold, 1);
    tick(); tick(); tick();
    ex_busy = 1'b0; #2;
    chk("b_stall_cnt_sat", b_stall_cnt, 3);

    // Multi-cycle EX: add x5,x1,x2 ; mul x6,x5,x5 busy for 3 cycles
    do_reset();
    set_id(5'd1, 5'd2, 2'b11, 5'd5, 1'b0);
    tick();
    set_id(5'd5, 5'd5, 2'b11, 5'd6, 1'b0);
    tick();
    idle(); ex_busy = 1'b1; #2;
    chk("busy_fwd_first", a_fwd_sel, 4'b0101);
    chk("busy_hold1", a_ex_hold, 1);
    chk("busy_pc_stall", a_pc_stall, 1);
    chk("busy_no_bubble", a_id_ex_bubble, 0);
    tick(); #1;
    chk("busy_fwd_later", a_fwd_sel, 0);
    chk("busy_hold2", a_ex_hold, 1);
    tick(); #1;
    chk("busy_hold3", a_ex_hold, 1);
    tick();
    ex_busy = 1'b0; #2;
    chk("busy_done", a_ex_hold, 0);
    chk("busy_stall_cnt", a_stall_cnt, 3);

    // Load-use coinciding with redirect: the flush wins
    do_reset();
    set_id(5'd1, 5'd0, 2'b01, 5'd5, 1'b1);
    tick();
    set_id(5'd5, 5'd0, 2'b11, 5'd6, 1'b0); ex_redirect = 1'b1; #2;
    chk("redir_pc_stall", a_pc_stall, 0);
    chk("redir_if_id_stall", a_if_id_stall, 0);
    chk("redir_flush", a_if_id_flush, 1);
    chk("redir_bubble", a_id_ex_bubble, 1);
    tick();
    idle(); ex_redirect = 1'b0; #2;
    chk("redir_flush_cnt", a_flush_cnt, 1);
    chk("redir_stall_cnt", a_stall_cnt, 0);
    ex_busy = 1'b1; ex_redirect = 1'b1; #1;
    chk("busy_over_redir", a_if_id_flush, 0);
    tick();
    ex_busy = 1'b0; ex_redirect = 1'b0; #2;
    chk("busy_redir_flush_cnt", a_flush_cnt, 1);
    chk("busy_redir_stall_cnt", a_stall_cnt, 1);

    // x0 producer never creates a hazard; unused source ignored
    do_reset();
    set_id(5'd1, 5'd0, 2'b01, 5'd0, 1'b1);
    tick();
    set_id(5'd0, 5'd0, 2'b11, 5'd6, 1'b0); #2;
    chk("x0_no_stall", a_pc_stall, 0);
    tick();
    idle(); #2;
    chk("x0_fwd", a_fwd_sel, 0);
    set_id(5'd1, 5'd0, 2'b01, 5'd5, 1'b1);
    tick();
    set_id(5'd5, 5'd1, 2'b10, 5'd6, 1'b0); #2;
    chk("unused_src_no_stall", a_pc_stall, 0);

    // Reset in the middle of a load-use stall
    do_reset();
    set_id(5'd1, 5'd0, 2'b01, 5'd5, 1'b1);
    tick();
    set_id(5'd5, 5'd0, 2'b11, 5'd6, 1'b0); #2;
    chk("mid_pre_stall", a_pc_stall, 1);
    reset = 1'b1; #1;
    chk("mid_rst_pc_stall", a_pc_stall, 0);
    chk("mid_rst_bubble", a_id_ex_bubble, 0);
    tick();
    reset = 1'b0; #2;
    chk("mid_after_pc_stall", a_pc_stall, 0);
    chk("mid_after_stall_cnt", a_stall_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
